satd4x4_engine: RTL and testbench

Pipelined 4x4 Hadamard SATD engine for the fractional motion-estimation (FME) datapath. It accepts residual rows as reference/current pixel pairs and computes the 2-D Hadamard transform in a row pass and a column pass, using a registered transpose buffer between them. It sums absolute coefficients per block and accumulates NUM_BLK blocks into one partition cost for the FME decision logic. It is the parametrised, handshaked successor of the fixed 8-bit single-block transform unit.

---
 rtl/satd4x4_engine.sv | 192 +++++++++++++++++++
 tb/tb_satd4x4_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/satd4x4_engine.sv
// satd4x4_engine: pipelined 4x4 Hadamard SATD engine for the FME datapath.
// Row pass on each accepted residual row into a registered transpose buffer, then a
// four-cycle column pass that sums absolute coefficients. NUM_BLK block costs are
// accumulated (saturating) into one partition result behind a valid/ready handshake.
// Optional build macro: SATD4X4_HALF_EN -- when defined, satd = (acc+1)>>1.
module satd4x4_engine #(
  parameter int unsigned PIX_W   = 8,
  parameter int unsigned NUM_BLK = 4,
  parameter int unsigned OUT_W   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4*PIX_W-1:0] in_ref,
  input  logic [4*PIX_W-1:0] in_cur,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   satd
);

  localparam int unsigned DW  = PIX_W + 1;  // pixel difference
  localparam int unsigned RW  = PIX_W + 3;  // row-pass coefficient
  localparam int unsigned CW  = PIX_W + 5;  // column-pass coefficient
  localparam int unsigned BW  = PIX_W + 9;  // per-block magnitude sum
  localparam int unsigned SW  = ((OUT_W > BW) ? OUT_W : BW) + 1;  // headroom for acc+blk_sum
  localparam int unsigned BCW = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;

  localparam logic [OUT_W-1:0] AccMax  = '1;
  localparam logic [BCW-1:0]   BlkLast = BCW'(NUM_BLK - 1);

  typedef enum logic [1:0] {StRow, StCol, StOut} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             row_cnt_q, row_cnt_d;
  logic [1:0]             col_cnt_q, col_cnt_d;
  logic [BCW-1:0]         blk_cnt_q, blk_cnt_d;
  logic signed [RW-1:0]   tbuf_q [4][4];
  logic signed [RW-1:0]   tbuf_d [4][4];
  logic [BW-1:0]          blk_sum_q, blk_sum_d;
  logic [OUT_W-1:0]       acc_q, acc_d;

  // Row pass signals
  logic signed [DW-1:0]   diff [4];
  logic signed [RW-1:0]   row_e [4];
  logic signed [RW-1:0]   row_s0, row_s1, row_t0, row_t1;
  logic signed [RW-1:0]   row_h [4];

  // Column pass signals
  logic signed [CW-1:0]   col_e [4];
  logic signed [CW-1:0]   col_s0, col_s1, col_t0, col_t1;
  logic signed [CW-1:0]   col_h [4];
  logic [CW-1:0]          col_abs [4];
  logic [BW-1:0]          col_sum;
  logic [BW-1:0]          blk_sum_nx;
  logic [SW-1:0]          acc_sum;
  logic [OUT_W-1:0]       acc_sat;

  // Row butterfly on the incoming residual row
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      diff[k]  = $signed({1'b0, in_cur[k*PIX_W +: PIX_W]})
               - $signed({1'b0, in_ref[k*PIX_W +: PIX_W]});
      row_e[k] = {{2{diff[k][DW-1]}}, diff[k]};
    end
    row_s0   = row_e[0] + row_e[3];
    row_s1   = row_e[1] + row_e[2];
    row_t1   = row_e[1] - row_e[2];
    row_t0   = row_e[0] - row_e[3];
    row_h[0] = row_s0 + row_s1;
    row_h[1] = row_t1 + row_t0;
    row_h[2] = row_s0 - row_s1;
    row_h[3] = row_t0 - row_t1;
  end

  // Column butterfly on transpose column col_cnt, magnitudes and saturating accumulate
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      col_e[r] = {{2{tbuf_q[r][col_cnt_q][RW-1]}}, tbuf_q[r][col_cnt_q]};
    end
    col_s0   = col_e[0] + col_e[3];
    col_s1   = col_e[1] + col_e[2];
    col_t1   = col_e[1] - col_e[2];
    col_t0   = col_e[0] - col_e[3];
    col_h[0] = col_s0 + col_s1;
    col_h[1] = col_t1 + col_t0;
    col_h[2] = col_s0 - col_s1;
    col_h[3] = col_t0 - col_t1;
    for (int k = 0; k < 4; k++) begin
      col_abs[k] = col_h[k][CW-1] ? -col_h[k] : col_h[k];
    end
    col_sum = {{(BW-CW){1'b0}}, col_abs[0]} + {{(BW-CW){1'b0}}, col_abs[1]}
            + {{(BW-CW){1'b0}}, col_abs[2]} + {{(BW-CW){1'b0}}, col_abs[3]};
    // Last column folds its own magnitudes in before the block cost reaches acc
    blk_sum_nx = blk_sum_q + col_sum;
    acc_sum    = {{(SW-OUT_W){1'b0}}, acc_q} + {{(SW-BW){1'b0}}, blk_sum_nx};
    acc_sat    = (acc_sum > {{(SW-OUT_W){1'b0}}, AccMax}) ? AccMax : acc_sum[OUT_W-1:0];
  end

  // Next-state logic for the FSM, counters, transpose buffer and accumulators
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    blk_cnt_d = blk_cnt_q;
    tbuf_d    = tbuf_q;
    blk_sum_d = blk_sum_q;
    acc_d     = acc_q;
    unique case (state_q)
      StRow: begin
        if (in_valid) begin
          for (int k = 0; k < 4; k++) begin
            tbuf_d[row_cnt_q][k] = row_h[k];
          end
          row_cnt_d = row_cnt_q + 2'd1;
          if (row_cnt_q == 2'd3) begin
            state_d = StCol;
          end
        end
      end
      StCol: begin
        col_cnt_d = col_cnt_q + 2'd1;
        blk_sum_d = blk_sum_nx;
        if (col_cnt_q == 2'd3) begin
          acc_d     = acc_sat;
          blk_sum_d = '0;
          if (blk_cnt_q == BlkLast) begin
            blk_cnt_d = '0;
            state_d   = StOut;
          end else begin
            blk_cnt_d = blk_cnt_q + BCW'(1);
            state_d   = StRow;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = StRow;
        end
      end
      default: state_d = StRow;
    endcase
  end

  // State and datapath registers; reset aborts any partial row, block or result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRow;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      blk_cnt_q <= '0;
      blk_sum_q <= '0;
      acc_q     <= '0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          tbuf_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      blk_cnt_q <= blk_cnt_d;
      blk_sum_q <= blk_sum_d;
      acc_q     <= acc_d;
      tbuf_q    <= tbuf_d;
    end
  end

  // Handshake outputs depend on state only
  always_comb begin
    in_ready  = (state_q == StRow);
    out_valid = (state_q == StOut);
  end

`ifdef SATD4X4_HALF_EN
  logic [OUT_W:0] acc_inc;

  // Rounded halving of the (possibly saturated) accumulated cost
  always_comb begin
    acc_inc = {1'b0, acc_q} + {{OUT_W{1'b0}}, 1'b1};
    satd    = acc_inc[OUT_W:1];
  end
`else
  // Unscaled accumulated cost
  always_comb begin
    satd = acc_q;
  end
`endif

endmodule

// File: tb/tb_satd4x4_engine.sv
// Directed self-checking bench for satd4x4_engine. Three instances share the input bus:
// default (NUM_BLK=4, OUT_W=20), single-block (NUM_BLK=1) and a narrow saturating one
// (OUT_W=12, NUM_BLK=16). 'sel' picks which instance the tasks observe.
module tb_satd4x4_engine;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_ref;
  logic [31:0] in_cur;
  logic        out_ready;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [19:0] satd0, satd1;
  logic [11:0] satd2;

  int          sel;
  logic        rdy_s, ov_s;
  logic [31:0] satd_s;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          t_first;
  int          t_out;
  bit          first_hs;

  satd4x4_engine #(.PIX_W(8), .NUM_BLK(4), .OUT_W(20)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_ref(in_ref),
    .in_cur(in_cur), .out_valid(ov0), .out_ready(out_ready), .satd(satd0)
  );

  satd4x4_engine #(.PIX_W(8), .NUM_BLK(1), .OUT_W(20)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_ref(in_ref),
    .in_cur(in_cur), .out_valid(ov1), .out_ready(out_ready), .satd(satd1)
  );

  satd4x4_engine #(.PIX_W(8), .NUM_BLK(16), .OUT_W(12)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_ref(in_ref),
    .in_cur(in_cur), .out_valid(ov2), .out_ready(out_ready), .satd(satd2)
  );

  assign rdy_s  = (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
  assign ov_s   = (sel == 0) ? ov0 : (sel == 1) ? ov1 : ov2;
  assign satd_s = (sel == 0) ? {12'd0, satd0} : (sel == 1) ? {12'd0, satd1} : {20'd0, satd2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned scale(input int unsigned v);
`ifdef SATD4X4_HALF_EN
    return (v + 1) >> 1;
`else
    return v;
`endif
  endfunction

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the row is accepted
  task automatic send_row(input logic [31:0] r, input logic [31:0] c);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_ref   = r;
    in_cur   = c;
    while (!rdy_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("row_accept_timeout", 0, 1);
    if (first_hs) begin
      t_first  = cyc;
      first_hs = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One 4x4 block: uniform ref rv / cur cv, except cur pixel (0,0) = c00
  task automatic send_block(input logic [7:0] rv, input logic [7:0] cv, input logic [7:0] c00,
                            input int gap);
    logic [31:0] rrow, crow;
    for (int r = 0; r < 4; r++) begin
      rrow = {4{rv}};
      crow = {4{cv}};
      if (r == 0) crow[7:0] = c00;
      send_row(rrow, crow);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_part(input int nblk, input logic [7:0] rv, input logic [7:0] cv,
                           input int gap);
    for (int b = 0; b < nblk; b++) send_block(rv, cv, cv, gap);
  endtask

  task automatic wait_result(input string tag);
    int n;
    n = 0;
    while (!ov_s && n < 2000) begin
      @(negedge clk);
      n++;
    end
    t_out = cyc;
    if (n >= 2000) check_eq(tag, 0, 1);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned held;
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    sel       = 0;
    first_hs  = 1'b0;
    in_valid  = 1'b0;
    in_ref    = '0;
    in_cur    = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("reset_in_ready", rdy0, 1);
    check_eq("reset_out_valid", ov0, 0);
    check_eq("reset_satd", satd0, 0);
    check_eq("reset_sat_in_ready", rdy2, 1);

    // Zero residual, back-to-back rows: 32-cycle latency, satd 0
    sel      = 0;
    first_hs = 1'b1;
    send_part(4, 8'd100, 8'd100, 0);
    wait_result("zero_timeout");
    check_eq("zero_latency", t_out - t_first, 32);
    check_eq("zero_out_valid", ov_s, 1);
    check_eq("zero_satd", satd_s, scale(0));
    take_result();

    // Single-pixel spike, NUM_BLK=1: 16 coefficients of magnitude 10
    apply_reset();
    sel = 1;
    send_block(8'd0, 8'd0, 8'd10, 0);
    wait_result("spike_timeout");
    check_eq("spike_satd", satd_s, scale(160));
    check_eq("spike_in_ready_out", rdy_s, 0);
    take_result();
    check_eq("spike_in_ready_after", rdy_s, 1);

    // Uniform difference 5 with in_valid gaps: DC-only 80 per block
    apply_reset();
    sel = 0;
    send_part(4, 8'd20, 8'd25, 2);
    wait_result("uniform_timeout");
    check_eq("uniform_gap_satd", satd_s, scale(320));
    take_result();

    // Saturation: 4080 per block, 16 blocks into 12 bits
    apply_reset();
    sel = 2;
    send_part(16, 8'd0, 8'd255, 0);
    wait_result("sat_timeout");
    check_eq("sat_satd", satd_s, scale(4095));
    take_result();

    // Backpressure: result held stable with out_ready low, then fresh start from acc=0
    apply_reset();
    sel = 0;
    send_part(4, 8'd7, 8'd12, 0);
    wait_result("stall_timeout");
    held = satd_s;
    check_eq("stall_satd", held, scale(320));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_out_valid", ov_s, 1);
      check_eq("stall_satd_stable", satd_s, held);
      check_eq("stall_in_ready", rdy_s, 0);
    end
    take_result();
    check_eq("release_in_ready", rdy_s, 1);
    check_eq("release_out_valid", ov_s, 0);
    send_part(4, 8'd50, 8'd50, 0);
    wait_result("after_stall_timeout");
    check_eq("after_stall_satd", satd_s, scale(0));
    take_result();

    // Reset during the 2nd COL cycle of block 2 discards everything
    apply_reset();
    sel = 0;
    send_block(8'd0, 8'd255, 8'd255, 0);
    send_block(8'd0, 8'd200, 8'd3, 0);
    @(negedge clk);
    apply_reset();
    check_eq("abort_out_valid", ov_s, 0);
    check_eq("abort_in_ready", rdy_s, 1);
    check_eq("abort_satd", satd_s, 0);
    send_part(4, 8'd30, 8'd35, 0);
    wait_result("abort_timeout");
    check_eq("abort_next_satd", satd_s, scale(320));
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
